// File: rtl/pipe_pkg.sv
// Shared definitions for handshaked pipeline stages: state encoding,
// occupancy codes and default widths.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } ps_state_e;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

  localparam int DEF_CTRL_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_CNT_WIDTH  = 16;

  // Number of entries held in a given state.
  function automatic logic [1:0] occ_of_state(input ps_state_e s);
    case (s)
      PS_ONE:  return OCC_ONE;
      PS_TWO:  return OCC_TWO;
      default: return OCC_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] cnt
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end
    return v + CNT_WIDTH'(1);
  endfunction

  // Next count: clear first, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = sat_inc(cnt_q);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_hs.sv
// Generic valid/ready pipeline boundary register. With SKID=1 a second
// (overflow) entry lets in_ready come straight from a flop; with SKID=0 the
// stage is a single register with pass-through ready. Flush turns every held
// entry into a zero-control bubble. A saturating counter records stall cycles.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int CTRL_WIDTH        = DEF_CTRL_WIDTH,
  parameter int DATA_WIDTH        = DEF_DATA_WIDTH,
  parameter int SKID              = 1,
  parameter int FLUSH_CLEARS_DATA = 0,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam bit USE_SKID   = (SKID != 0);
  localparam bit CLR_DATA   = (FLUSH_CLEARS_DATA != 0);

  ps_state_e             state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [CTRL_WIDTH-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_WIDTH-1:0] main_data_q, main_data_d;
  logic [CTRL_WIDTH-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;

  logic xfer_in;
  logic xfer_out;
  logic stall;

  assign out_valid = (state_q != PS_EMPTY);
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready;

  // With a skid entry, ready is a pure function of the state flop; without
  // one, the single register can reload in the same cycle it drains.
  generate
    if (USE_SKID) begin : g_skid_ready
      assign in_ready = (state_q != PS_TWO);
    end else begin : g_pass_ready
      assign in_ready = (state_q == PS_EMPTY) | out_ready;
    end
  endgenerate

  // Next-state and entry movement. Every path that empties a register also
  // zeroes its control field so a bubble never carries live control bits.
  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Any input offered this cycle is dropped; an output taken this cycle
      // has already been sampled downstream, so nothing else is needed.
      state_d     = PS_EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
      if (CLR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (xfer_in) begin
            state_d     = PS_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        PS_ONE: begin
          if (xfer_in && xfer_out) begin
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else if (xfer_in && USE_SKID) begin
            // Downstream stalled: park the new entry behind the main one.
            state_d     = PS_TWO;
            skid_ctrl_d = in_ctrl;
            skid_data_d = in_data;
          end else if (xfer_out) begin
            state_d     = PS_EMPTY;
            main_ctrl_d = '0;
          end
        end
        PS_TWO: begin
          if (out_ready) begin
            // Older main entry leaves; skid entry moves up, keeping FIFO order.
            state_d     = PS_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = PS_EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end

    occ_d = occ_of_state(state_d);
  end

  // State, occupancy and entry registers; all return to zero on reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PS_EMPTY;
      occ_q       <= OCC_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign out_ctrl  = main_ctrl_q;
  assign out_data  = main_data_q;
  assign occupancy = occ_q;

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset_n),
    .inc   (stall),
    .clr   (cnt_clr),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: instance A (SKID=1, payload kept on flush,
// 16-bit counter) and instance B (SKID=0, payload cleared on flush,
// 4-bit counter), checked against a FIFO scoreboard plus a vector table.
module tb_pipe_stage_hs;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv   [2];
  logic        ordy [2];
  logic        fl   [2];
  logic        clr  [2];
  logic [7:0]  ic   [2];
  logic [63:0] idat [2];

  logic        ir_a, ir_b, ov_a, ov_b;
  logic [7:0]  oc_a, oc_b;
  logic [63:0] od_a, od_b;
  logic [1:0]  occ_a, occ_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  pipe_stage_hs #(.CTRL_WIDTH(8), .DATA_WIDTH(64), .SKID(1),
                  .FLUSH_CLEARS_DATA(0), .CNT_WIDTH(16)) u_a (
    .clk(clk), .reset_n(reset_n), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir_a), .in_ctrl(ic[0]), .in_data(idat[0]),
    .out_valid(ov_a), .out_ready(ordy[0]), .out_ctrl(oc_a), .out_data(od_a),
    .occupancy(occ_a), .cnt_clr(clr[0]), .stall_cnt(cnt_a));

  pipe_stage_hs #(.CTRL_WIDTH(8), .DATA_WIDTH(64), .SKID(0),
                  .FLUSH_CLEARS_DATA(1), .CNT_WIDTH(4)) u_b (
    .clk(clk), .reset_n(reset_n), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir_b), .in_ctrl(ic[1]), .in_data(idat[1]),
    .out_valid(ov_b), .out_ready(ordy[1]), .out_ctrl(oc_b), .out_data(od_b),
    .occupancy(occ_b), .cnt_clr(clr[1]), .stall_cnt(cnt_b));

  int errors = 0;
  int checks = 0;

  // Scoreboard and reference state per instance.
  logic [71:0] qa[$];
  logic [71:0] qb[$];
  logic [63:0] hold [2];
  int unsigned mcnt [2];
  int          n_out [2];
  logic        acc [2];

  typedef struct packed {
    logic        iv;
    logic [7:0]  c;
    logic [63:0] dat;
    logic        ordy;
    logic        fl;
    logic        clr;
    logic        e_ov;
    logic [1:0]  e_occ;
    logic        e_ir;
    logic [7:0]  e_ctl;
    logic [63:0] e_dat;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [13];

  function automatic vec_t mk(input logic v, input logic [7:0] c, input logic [63:0] dat,
                              input logic r, input logic f, input logic cl,
                              input logic eov, input logic [1:0] eocc, input logic eir,
                              input logic [7:0] ectl, input logic [63:0] edat,
                              input logic [15:0] ecnt);
    vec_t x;
    x.iv = v; x.c = c; x.dat = dat; x.ordy = r; x.fl = f; x.clr = cl;
    x.e_ov = eov; x.e_occ = eocc; x.e_ir = eir; x.e_ctl = ectl;
    x.e_dat = edat; x.e_cnt = ecnt;
    return x;
  endfunction

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  function automatic int sb_size(input int d);
    return (d == 0) ? qa.size() : qb.size();
  endfunction

  function automatic logic [71:0] sb_front(input int d);
    return (d == 0) ? qa[0] : qb[0];
  endfunction

  task automatic sb_push(input int d, input logic [71:0] v);
    if (d == 0) qa.push_back(v);
    else qb.push_back(v);
  endtask

  task automatic sb_pop(input int d);
    if (d == 0) void'(qa.pop_front());
    else void'(qb.pop_front());
  endtask

  task automatic sb_clear(input int d);
    if (d == 0) qa.delete();
    else qb.delete();
  endtask

  // Compare one instance against the reference, then advance the reference
  // by the transfers that the coming clock edge will perform.
  task automatic observe(input int d);
    int          sz;
    logic        eov, eir, xin, xout;
    logic [71:0] fr;
    logic [7:0]  ectl;
    logic [63:0] edat;
    int unsigned cmax;
    sz   = sb_size(d);
    eov  = (sz > 0);
    eir  = (d == 0) ? (sz < 2) : ((sz == 0) || ordy[d]);
    fr   = eov ? sb_front(d) : 72'd0;
    ectl = eov ? fr[71:64] : 8'h00;
    edat = eov ? fr[63:0] : hold[d];
    cmax = (d == 0) ? 32'hFFFF : 32'hF;
    chk("out_valid", d, 64'((d == 0) ? ov_a : ov_b), 64'(eov));
    chk("in_ready",  d, 64'((d == 0) ? ir_a : ir_b), 64'(eir));
    chk("occupancy", d, 64'((d == 0) ? occ_a : occ_b), 64'(sz));
    chk("out_ctrl",  d, 64'((d == 0) ? oc_a : oc_b), 64'(ectl));
    chk("out_data",  d, (d == 0) ? od_a : od_b, edat);
    chk("stall_cnt", d, (d == 0) ? 64'(cnt_a) : 64'(cnt_b), 64'(mcnt[d]));
    xin    = iv[d] && eir;
    xout   = eov && ordy[d];
    acc[d] = xin;
    if (clr[d]) mcnt[d] = 0;
    else if (eov && !ordy[d] && (mcnt[d] < cmax)) mcnt[d] = mcnt[d] + 1;
    if (eov) hold[d] = fr[63:0];
    if (xout) begin
      sb_pop(d);
      n_out[d]++;
    end
    if (fl[d]) begin
      sb_clear(d);
      if (d == 1) hold[d] = 64'd0;
    end else if (xin) begin
      sb_push(d, {ic[d], idat[d]});
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next one.
  task automatic cycle();
    #2;
    observe(0);
    observe(1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int d);
    iv[d] = 1'b0; ordy[d] = 1'b1; fl[d] = 1'b0; clr[d] = 1'b0;
    ic[d] = 8'h00; idat[d] = 64'd0;
  endtask

  // Assert reset between edges, confirm outputs clear at once, then release.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_ov_a",  0, 64'(ov_a), 64'd0);
    chk("rst_oc_a",  0, 64'(oc_a), 64'd0);
    chk("rst_od_a",  0, od_a, 64'd0);
    chk("rst_occ_a", 0, 64'(occ_a), 64'd0);
    chk("rst_ir_a",  0, 64'(ir_a), 64'd1);
    chk("rst_cnt_a", 0, 64'(cnt_a), 64'd0);
    chk("rst_ov_b",  1, 64'(ov_b), 64'd0);
    chk("rst_oc_b",  1, 64'(oc_b), 64'd0);
    chk("rst_od_b",  1, od_b, 64'd0);
    chk("rst_occ_b", 1, 64'(occ_b), 64'd0);
    chk("rst_cnt_b", 1, 64'(cnt_b), 64'd0);
    for (int d = 0; d < 2; d++) begin
      sb_clear(d);
      hold[d] = 64'd0;
      mcnt[d] = 0;
      idle(d);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int k;
    int base;

    for (int d = 0; d < 2; d++) begin
      idle(d);
      hold[d] = 64'd0; mcnt[d] = 0; n_out[d] = 0; acc[d] = 1'b0;
    end

    //          iv  ctrl   data    ordy fl clr | ov occ ir ctrl  data    cnt
    tbl[0]  = mk(1, 8'hA5, 64'h1234, 1, 0, 0,   1, 1, 1, 8'hA5, 64'h1234, 0);
    tbl[1]  = mk(1, 8'h01, 64'h11,   0, 0, 0,   1, 2, 0, 8'hA5, 64'h1234, 1);
    tbl[2]  = mk(1, 8'h02, 64'h22,   0, 0, 0,   1, 2, 0, 8'hA5, 64'h1234, 2);
    tbl[3]  = mk(1, 8'h02, 64'h22,   1, 0, 0,   1, 1, 1, 8'h01, 64'h11,   2);
    tbl[4]  = mk(1, 8'h02, 64'h22,   1, 0, 0,   1, 1, 1, 8'h02, 64'h22,   2);
    tbl[5]  = mk(0, 8'h00, 64'h0,    1, 0, 0,   0, 0, 1, 8'h00, 64'h22,   2);
    tbl[6]  = mk(1, 8'h03, 64'h33,   0, 0, 0,   1, 1, 1, 8'h03, 64'h33,   2);
    tbl[7]  = mk(1, 8'h04, 64'h44,   0, 0, 0,   1, 2, 0, 8'h03, 64'h33,   3);
    tbl[8]  = mk(1, 8'h05, 64'h55,   0, 1, 0,   0, 0, 1, 8'h00, 64'h33,   4);
    tbl[9]  = mk(0, 8'h00, 64'h0,    1, 0, 0,   0, 0, 1, 8'h00, 64'h33,   4);
    tbl[10] = mk(0, 8'h00, 64'h0,    1, 0, 1,   0, 0, 1, 8'h00, 64'h33,   0);
    tbl[11] = mk(1, 8'h06, 64'h66,   1, 0, 0,   1, 1, 1, 8'h06, 64'h66,   0);
    tbl[12] = mk(1, 8'h07, 64'h77,   1, 1, 0,   0, 0, 1, 8'h00, 64'h66,   0);

    @(negedge clk);
    do_reset();

    // Directed vectors on the skid instance; expectations are post-edge.
    for (int i = 0; i < 13; i++) begin
      iv[0] = tbl[i].iv; ic[0] = tbl[i].c; idat[0] = tbl[i].dat;
      ordy[0] = tbl[i].ordy; fl[0] = tbl[i].fl; clr[0] = tbl[i].clr;
      cycle();
      chk($sformatf("tbl%0d_ov", i),   0, 64'(ov_a),  64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occ", i),  0, 64'(occ_a), 64'(tbl[i].e_occ));
      chk($sformatf("tbl%0d_ir", i),   0, 64'(ir_a),  64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_ctl", i),  0, 64'(oc_a),  64'(tbl[i].e_ctl));
      chk($sformatf("tbl%0d_dat", i),  0, od_a,       tbl[i].e_dat);
      chk($sformatf("tbl%0d_cnt", i),  0, 64'(cnt_a), 64'(tbl[i].e_cnt));
    end
    idle(0);

    // Ten back-to-back entries with downstream always ready.
    base = n_out[0];
    for (int i = 0; i < 10; i++) begin
      iv[0] = 1'b1; ic[0] = 8'(i + 16); idat[0] = 64'(i * 3 + 100); ordy[0] = 1'b1;
      cycle();
    end
    iv[0] = 1'b0;
    cycle();
    chk("stream_count", 0, 64'(n_out[0] - base), 64'd10);
    chk("stream_stall", 0, 64'(cnt_a), 64'd0);

    // Back-pressure: entries 1,2 accepted, entry 3 held upstream.
    k = 1;
    ordy[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      iv[0] = 1'b1; ic[0] = 8'(k); idat[0] = 64'(k);
      cycle();
      if (acc[0]) k++;
    end
    chk("bp_occ",   0, 64'(occ_a), 64'd2);
    chk("bp_ready", 0, 64'(ir_a),  64'd0);
    chk("bp_stall", 0, 64'(cnt_a), 64'd4);
    base = n_out[0];
    ordy[0] = 1'b1;
    for (int c = 0; c < 8; c++) begin
      iv[0] = (k <= 3); ic[0] = 8'(k); idat[0] = 64'(k);
      cycle();
      if (acc[0]) k++;
    end
    chk("bp_drain_count", 0, 64'(n_out[0] - base), 64'd3);
    chk("bp_stall_kept",  0, 64'(cnt_a), 64'd4);
    idle(0);

    // 4-bit counter saturates under a long stall, then clears.
    iv[1] = 1'b1; ic[1] = 8'h5A; idat[1] = 64'hABCD; ordy[1] = 1'b0;
    cycle();
    iv[1] = 1'b0;
    for (int c = 0; c < 20; c++) cycle();
    chk("sat_cnt", 1, 64'(cnt_b), 64'hF);
    clr[1] = 1'b1;
    cycle();
    clr[1] = 1'b0;
    chk("sat_clr", 1, 64'(cnt_b), 64'd0);

    // Flush on the clearing-data instance zeroes the payload too.
    fl[1] = 1'b1; iv[1] = 1'b1; ic[1] = 8'h77; idat[1] = 64'h9999;
    cycle();
    fl[1] = 1'b0; iv[1] = 1'b0; ordy[1] = 1'b1;
    chk("flush_b_ov",  1, 64'(ov_b), 64'd0);
    chk("flush_b_ctl", 1, 64'(oc_b), 64'd0);
    chk("flush_b_dat", 1, od_b, 64'd0);
    cycle();

    // Pass-through ready with out_ready toggling and continuous input.
    k = 1;
    base = n_out[1];
    for (int c = 0; c < 20; c++) begin
      ordy[1] = ((c % 2) == 0);
      iv[1] = 1'b1; ic[1] = 8'(k + 64); idat[1] = 64'(k) * 64'd7;
      cycle();
      if (acc[1]) k++;
    end
    iv[1] = 1'b0; ordy[1] = 1'b1;
    cycle();
    chk("toggle_count", 1, 64'(n_out[1] - base), 64'd10);

    // Reset in the middle of traffic on both instances.
    iv[0] = 1'b1; ic[0] = 8'h3C; idat[0] = 64'hC0DE; ordy[0] = 1'b0;
    iv[1] = 1'b1; ic[1] = 8'hC3; idat[1] = 64'hFACE; ordy[1] = 1'b0;
    cycle();
    cycle();
    do_reset();
    cycle();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_hs.md
Name: pipe_stage_hs

Overview:
- Generalised, parametrised inter-stage pipeline register; replaces the fixed per-boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data payload with a valid/ready handshake.
- Optional 2-entry skid buffer so back-pressure does not create a combinational ready path; flush squashes entries to zero-control bubbles.
- Saturating stall counter for performance debug.

Parameters:
- CTRL_WIDTH, 8: width of control bundle (reg_write, mem_read, alu_op, ...), zeroed on bubble/flush.
- DATA_WIDTH, 64: width of payload (pc, operands, imm, reg addrs concatenated).
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single entry, pass-through ready.
- FLUSH_CLEARS_DATA, 0: 1 = flush also zeroes payload registers; 0 = payload held (ctrl always cleared).
- CNT_WIDTH, 16: stall counter width.

Ports:
- clk, input, 1: clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- flush, input, 1: squash all held entries, synchronous.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: stage can accept.
- in_ctrl, input, CTRL_WIDTH: upstream control.
- in_data, input, DATA_WIDTH: upstream payload.
- out_valid, output, 1: entry presented downstream.
- out_ready, input, 1: downstream accepts.
- out_ctrl, output, CTRL_WIDTH: control; all-zero whenever out_valid=0.
- out_data, output, DATA_WIDTH: payload.
- occupancy, output, 2: entries held (0..2).
- cnt_clr, input, 1: synchronous clear of stall_cnt.
- stall_cnt, output, CNT_WIDTH: cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (reset_n=0, async): state EMPTY; out_valid=0, out_ctrl=0, out_data=0, skid regs=0, occupancy=0, stall_cnt=0, in_ready=1 (derived from state).
- Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready; both sampled at posedge.
- Latency: 1 cycle in->out when empty; throughput 1/cycle with out_ready held high.

State machine (SKID=1), with main = output register and skid = overflow register:
- EMPTY: xfer_in -> ONE, main<=in.
- ONE: xfer_in & xfer_out -> ONE, main<=in.
- ONE: xfer_in & !out_ready -> TWO, skid<=in.
- ONE: !in_valid & xfer_out -> EMPTY, main ctrl<=0.
- TWO: out_ready -> ONE, main<=skid, skid ctrl<=0.
- TWO: else stays TWO.
- in_ready = (state != TWO), a pure function of the state register, with no combinational path from out_ready.
- Ordering is strictly FIFO; the skid entry never overtakes main.

SKID=0:
- States EMPTY/ONE only.
- in_ready = !out_valid | out_ready (combinational).
- ONE & xfer_in & xfer_out reloads main.

Flush (priority over everything except reset):
- Next state EMPTY; out_valid<=0; all ctrl regs<=0.
- Data regs zeroed only if FLUSH_CLEARS_DATA=1.
- An input transfer in the flush cycle is discarded. An output transfer in the flush cycle completes (downstream already sampled it).

Bubble invariant: out_ctrl==0 whenever out_valid==0, in every state and after every transition.

occupancy: EMPTY=0, ONE=1, TWO=2, registered.

stall_cnt:
- +1 on each cycle with out_valid & !out_ready, saturating at all-ones (no wrap).
- cnt_clr takes priority over increment.
- Flush does not clear it.

Mid-operation reset: async return to reset values in any state; the held entry is lost.

Decomposition:
- Shared package pipe_pkg: state encoding (PS_EMPTY=2'd0, PS_ONE=2'd1, PS_TWO=2'd2), occupancy constants, default width localparams.
- One sub-module, sat_counter (CNT_WIDTH, inc, clr, saturating), reused by other stages' perf counters.

Test Plan:
- Reset then in_valid=1, in_ctrl=8'hA5, in_data=64'h1234, out_ready=1 -> next cycle out_valid=1, out_ctrl=8'hA5, out_data=64'h1234, occupancy=1.
- Stream 10 entries, out_ready=1 -> 10 outputs in order on 10 consecutive cycles, stall_cnt=0.
- Hold out_ready=0, push entries 1,2,3 (SKID=1) -> after 2 accepts in_ready=0, occupancy=2, entry 3 held upstream. Release -> outputs 1,2,3 in order, stall_cnt counts the stalled cycles.
- occupancy=2, assert flush with in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1, flushed-cycle input never appears. With FLUSH_CLEARS_DATA=0, out_data is unchanged.
- CNT_WIDTH=4, hold stall 20 cycles -> stall_cnt=4'hF. Pulse cnt_clr -> 0 next cycle.
- SKID=0, out_ready toggling 1/0 each cycle with continuous input -> in_ready follows !out_valid|out_ready combinationally, no loss or duplication. reset_n low mid-stream -> all outputs 0 immediately.
